ipsxe_fft_peak_detect: RTL

Streaming spectral peak detector on the FFT result (xk) AXI4-Stream, directly downstream of the FFT core and alongside the frame checker in the onboard test top. Per frame it computes the L1 magnitude |re|+|im| of every bin and reports the bin index and magnitude of the largest one when the frame ends. It also counts frames and flags frame-length violations. It has no backpressure: it accepts one beat on every clock-enabled cycle with tvalid high.

---
 rtl/ipsxe_fft_peak_detect.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ipsxe_fft_peak_detect.sv
// ipsxe_fft_peak_detect
//
// Streaming spectral peak detector on the FFT result AXI4-Stream. For every
// frame it computes the L1 magnitude |re|+|im| of each bin and, when the frame
// ends, reports the index and magnitude of the largest bin. It also counts
// completed frames and keeps a sticky frame-length error flag. There is no
// backpressure: a beat is taken on every enabled cycle with tvalid high.
//
// Pipeline: S1 abs(re)/abs(im) -> S2 magnitude -> S3 running max -> result regs.
// A tlast beat sampled at enabled edge T shows o_peak_valid after edge T+3.
//
// Ports:
//   i_aclk, i_areset (async, active high), i_aclken (global clock enable)
//   i_clr                  synchronous clear, qualified by i_aclken
//   i_axi4s_data_*         FFT xk stream (re/im lanes in tdata, bin index in tuser)
//   o_peak_valid           one enabled cycle strobe per completed frame
//   o_peak_index/o_peak_mag  peak bin and its unsigned L1 magnitude
//   o_frame_cnt            completed frames (wraps)
//   o_len_err              sticky frame-length error
//
// Optional feature macro: IPSXE_FFT_PEAK_SKIP_DC_EN
//   defined   -> bin 0 is excluded from the peak search
//   undefined -> every bin is eligible

module ipsxe_fft_peak_detect #(
  parameter int unsigned LOG2_FFT_LEN  = 8,
  parameter int unsigned OUTPUT_WIDTH  = 25,
  parameter int unsigned DATAOUT_WIDTH = 32,
  parameter int unsigned USER_WIDTH    = 16
) (
  input  logic                         i_aclk,
  input  logic                         i_areset,
  input  logic                         i_aclken,
  input  logic                         i_clr,
  input  logic                         i_axi4s_data_tvalid,
  input  logic [2*DATAOUT_WIDTH-1:0]   i_axi4s_data_tdata,
  input  logic                         i_axi4s_data_tlast,
  input  logic [USER_WIDTH-1:0]        i_axi4s_data_tuser,
  output logic                         o_peak_valid,
  output logic [LOG2_FFT_LEN-1:0]      o_peak_index,
  output logic [OUTPUT_WIDTH:0]        o_peak_mag,
  output logic [15:0]                  o_frame_cnt,
  output logic                         o_len_err
);

  localparam int unsigned CNT_W = LOG2_FFT_LEN + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << LOG2_FFT_LEN) - 1);

  // Input decode
  logic [OUTPUT_WIDTH-1:0] w_re, w_im, w_re_abs, w_im_abs;
  logic [LOG2_FFT_LEN-1:0] w_idx;
  logic                    w_first;
  logic                    w_unused_bits;

  assign w_re  = i_axi4s_data_tdata[OUTPUT_WIDTH-1:0];
  assign w_im  = i_axi4s_data_tdata[DATAOUT_WIDTH +: OUTPUT_WIDTH];
  assign w_idx = i_axi4s_data_tuser[LOG2_FFT_LEN-1:0];
  // Unsigned result: abs(-2^(W-1)) wraps to 2^(W-1), which fits W bits.
  assign w_re_abs = w_re[OUTPUT_WIDTH-1] ? (~w_re + OUTPUT_WIDTH'(1)) : w_re;
  assign w_im_abs = w_im[OUTPUT_WIDTH-1] ? (~w_im + OUTPUT_WIDTH'(1)) : w_im;
  assign w_unused_bits = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

  // Control state
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_len_err;

  assign w_first = (r_beat_cnt == '0);

  // Stage registers
  logic                    r_s1_valid, r_s1_first, r_s1_last;
  logic [LOG2_FFT_LEN-1:0] r_s1_idx;
  logic [OUTPUT_WIDTH-1:0] r_s1_re_abs, r_s1_im_abs;

  logic                    r_s2_valid, r_s2_first, r_s2_last;
  logic [LOG2_FFT_LEN-1:0] r_s2_idx;
  logic [OUTPUT_WIDTH:0]   r_s2_mag;

  logic                    r_s3_done;
  logic                    r_have;
  logic [LOG2_FFT_LEN-1:0] r_max_idx;
  logic [OUTPUT_WIDTH:0]   r_max_mag;

  logic                    r_peak_valid;
  logic [LOG2_FFT_LEN-1:0] r_peak_idx;
  logic [OUTPUT_WIDTH:0]   r_peak_mag;
  logic [15:0]             r_frame_cnt;

  // Stage 1 + beat counter + length check
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_re_abs <= '0;
      r_s1_im_abs <= '0;
      r_beat_cnt  <= '0;
      r_len_err   <= 1'b0;
    end else if (i_aclken) begin
      if (i_clr) begin
        r_s1_valid <= 1'b0;
        r_beat_cnt <= '0;
        r_len_err  <= 1'b0;
      end else begin
        r_s1_valid  <= i_axi4s_data_tvalid;
        r_s1_first  <= w_first;
        r_s1_last   <= i_axi4s_data_tlast;
        r_s1_idx    <= w_idx;
        r_s1_re_abs <= w_re_abs;
        r_s1_im_abs <= w_im_abs;
        if (i_axi4s_data_tvalid) begin
          if (i_axi4s_data_tlast) begin
            r_beat_cnt <= '0;
            if (r_beat_cnt != LAST_BEAT) r_len_err <= 1'b1;
          end else if (r_beat_cnt == LAST_BEAT) begin
            // Missing tlast: wrap and start a new frame implicitly.
            r_beat_cnt <= '0;
            r_len_err  <= 1'b1;
          end else begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // Stage 2: magnitude, one extra bit so the sum never overflows
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_mag   <= '0;
    end else if (i_aclken) begin
      if (i_clr) begin
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_idx   <= r_s1_idx;
        r_s2_mag   <= {1'b0, r_s1_re_abs} + {1'b0, r_s1_im_abs};
      end
    end
  end

  // Stage 3: compare against the running maximum
  logic                    w_base_have, w_elig, w_take, w_new_have;
  logic [LOG2_FFT_LEN-1:0] w_base_idx, w_new_idx;
  logic [OUTPUT_WIDTH:0]   w_base_mag, w_new_mag;

  always_comb begin
    // The first beat of a frame sees an empty maximum: this is the re-arm.
    w_base_have = r_s2_first ? 1'b0 : r_have;
    w_base_idx  = r_s2_first ? '0   : r_max_idx;
    w_base_mag  = r_s2_first ? '0   : r_max_mag;
`ifdef IPSXE_FFT_PEAK_SKIP_DC_EN
    w_elig = (r_s2_idx != '0);
`else
    w_elig = 1'b1;
`endif
    // Strictly greater: on a tie the earlier bin is kept.
    w_take     = w_elig && (!w_base_have || (r_s2_mag > w_base_mag));
    w_new_have = w_base_have | w_take;
    w_new_idx  = w_take ? r_s2_idx : w_base_idx;
    w_new_mag  = w_take ? r_s2_mag : w_base_mag;
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_s3_done <= 1'b0;
      r_have    <= 1'b0;
      r_max_idx <= '0;
      r_max_mag <= '0;
    end else if (i_aclken) begin
      if (i_clr) begin
        r_s3_done <= 1'b0;
      end else begin
        r_s3_done <= r_s2_valid & r_s2_last;
        if (r_s2_valid) begin
          r_have    <= w_new_have;
          r_max_idx <= w_new_idx;
          r_max_mag <= w_new_mag;
        end
      end
    end
  end

  // Result registers; peak index/magnitude survive i_clr
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_peak_valid <= 1'b0;
      r_peak_idx   <= '0;
      r_peak_mag   <= '0;
      r_frame_cnt  <= '0;
    end else if (i_aclken) begin
      if (i_clr) begin
        r_peak_valid <= 1'b0;
        r_frame_cnt  <= '0;
      end else begin
        r_peak_valid <= r_s3_done;
        if (r_s3_done) begin
          r_peak_idx  <= r_max_idx;
          r_peak_mag  <= r_max_mag;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  assign o_peak_valid = r_peak_valid;
  assign o_peak_index = r_peak_idx;
  assign o_peak_mag   = r_peak_mag;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_len_err    = r_len_err;

endmodule
